// File: rtl/vend_pkg.sv
// Shared vending types: purchase/payment state encoding and the quantity-width helper.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    PAY    = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bits needed to hold a quantity of 0..sel_n.
  function automatic int unsigned qty_width(input int unsigned sel_n);
    return $clog2(sel_n + 1);
  endfunction

endpackage

// File: rtl/onehot_qty_decode.sv
// Turns one-hot quantity switches into a quantity (MSB = qty 1, LSB = qty SEL_N) plus a valid flag.
module onehot_qty_decode
  import vend_pkg::*;
#(
  parameter  int unsigned SEL_N = 7,
  localparam int unsigned QTY_W = qty_width(SEL_N)
) (
  input  logic [SEL_N-1:0] count,
  output logic [QTY_W-1:0] qty,
  output logic             valid
);

  always_comb begin
    valid = (count != '0) && ((count & (count - SEL_N'(1))) == '0);
    qty   = '0;
    for (int i = 0; i < int'(SEL_N); i++) begin
      if (count[i]) qty = QTY_W'(int'(SEL_N) - i);
    end
  end

endmodule

// File: rtl/purchase_entry_ctrl.sv
// Purchase-entry controller: validates a quantity selection against stock, then holds a pay request.
// Optional macro STOCK_CLAMP_EN: an over-stock selection buys the remaining stock instead of erroring.
module purchase_entry_ctrl
  import vend_pkg::*;
#(
  parameter  int unsigned SEL_N       = 7,
  parameter  int unsigned STOCK_W     = 3,
  parameter  int unsigned TIMEOUT_CYC = 1000,
  localparam int unsigned QTY_W       = qty_width(SEL_N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               query_en,
  input  logic               cancel,
  input  logic [STOCK_W-1:0] stock,
  input  logic [SEL_N-1:0]   count_in,
  input  logic               confirm,
  input  logic               pay_done,
  input  logic               pay_fail,
  output logic [QTY_W-1:0]   buy_count,
  output logic               enterpay,
  output logic               sale_ok,
  output logic               err,
  output logic               busy
);

  localparam int unsigned CMP_W = (STOCK_W > QTY_W) ? STOCK_W : QTY_W;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t             state_q, state_d;
  logic [QTY_W-1:0]   dec_qty;
  logic               dec_valid;
  logic [CMP_W-1:0]   stock_x, qty_x;
  logic [QTY_W-1:0]   latch_qty;
  logic               abort;
  logic               err_d, enterpay_d, sale_ok_d, busy_d;
  logic [QTY_W-1:0]   buy_count_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  onehot_qty_decode #(.SEL_N(SEL_N)) u_decode (
    .count (count_in),
    .qty   (dec_qty),
    .valid (dec_valid)
  );

  assign stock_x = CMP_W'(stock);
  assign qty_x   = CMP_W'(dec_qty);
  assign abort   = cancel || !query_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Transition decisions; err_d flags a rejected confirm or a failed/timed-out payment.
  always_comb begin
    state_d   = state_q;
    err_d     = 1'b0;
    latch_qty = dec_qty;
    case (state_q)
      IDLE: begin
        if (!abort) state_d = SELECT;
      end
      SELECT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (confirm) begin
          if (!dec_valid || stock_x == '0) begin
            err_d = 1'b1;
          end else if (qty_x <= stock_x) begin
            state_d = PAY;
          end else begin
`ifdef STOCK_CLAMP_EN
            latch_qty = QTY_W'(stock_x);
            state_d   = PAY;
`else
            err_d = 1'b1;
`endif
          end
        end
      end
      PAY: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pay_done) begin
          state_d = DONE;
        end else if (pay_fail || timer_q == TMR_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    buy_count_d = buy_count;
    if (state_d == IDLE)                           buy_count_d = '0;
    else if (state_q == SELECT && state_d == PAY)  buy_count_d = latch_qty;
    enterpay_d = (state_d == PAY);
    sale_ok_d  = (state_d == DONE);
    busy_d     = (state_d != IDLE);
    timer_d    = (state_q == PAY && state_d == PAY) ? timer_q + TMR_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buy_count <= '0;
      enterpay  <= 1'b0;
      sale_ok   <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      timer_q   <= '0;
    end else begin
      buy_count <= buy_count_d;
      enterpay  <= enterpay_d;
      sale_ok   <= sale_ok_d;
      err       <= err_d;
      busy      <= busy_d;
      timer_q   <= timer_d;
    end
  end

endmodule
